ssd_capture_decoder: RTL and testbench
======================================

# ssd_capture_decoder

Decodes a multiplexed, active-low seven-segment display bus (per-digit anode strobes plus shared segment lines) back into ASCII. It sits on the observation side of the display path. Stable segment patterns are captured per digit and assembled into frames. Each changed frame is emitted as a byte stream (digits MSD-first, then CR) on a valid/ready interface that feeds the UART transmitter.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), ≥1
- STABLE_CYCLES, 16, consecutive identical samples required before a digit is captured, ≥2
- clk  input  1  system clock; the only clock
- rst  input  1  reset, synchronous, active-high
- an  input  NUM_DIGITS  anode strobes, active-low; exactly one low selects digit index k
- seg  input  7  segment lines, active-low; seg[6]=g … seg[0]=a
- out_valid  output  1  out_data holds a byte
- out_ready  input  1  downstream accepts the byte when out_valid && out_ready
- out_data  output  8  ASCII byte
- overrun  output  1  one-cycle pulse: a pending frame was overwritten before it was sent

## Operation
- Stability filter: {an, seg} is compared with its previous-cycle value. Any difference clears the counter; otherwise the counter increments and saturates at STABLE_CYCLES. Counter width is $clog2(STABLE_CYCLES+1).
- Capture: fires once per stable period, on the edge where the counter reaches STABLE_CYCLES, and only if an is one-hot-low.
  - No capture for all-high (blanking) or for multiple-low strobes.
  - A capture stores seg into slot[k] and sets seen[k].
- Frame complete: seen becomes all ones. seen is then cleared on the same edge.
  - First frame after reset, or frame ≠ last_sent: the frame is a candidate.
  - Frame equal to last_sent: discarded.
- FSM states IDLE, SEND, TERM.
  - IDLE: a candidate (new or pending) loads buf, sets idx=NUM_DIGITS-1, and moves to SEND.
  - SEND: out_data = decode(buf[idx]). On accept: if idx>0, idx-1; otherwise go to TERM.
  - TERM: out_data = 8'h0D. On accept: last_sent ← buf, go to IDLE.
- A candidate arriving in SEND or TERM goes to a one-deep pending register.
  - If pending is already valid, it is overwritten and overrun pulses.
  - On entry to IDLE, pending is re-compared against the new last_sent and dropped if equal.
- Decode (pattern seg[6:0] → char). Digits take priority over letters; letter collisions resolve to the alphabetically first letter.
  - Digits: 1000000→"0", 1111001→"1", 0100100→"2", 0110000→"3", 0011001→"4", 0010010→"5", 0000010→"6", 1111000→"7", 0000000→"8", 0010000→"9".
  - Letters: 0001000→"A", 0000011→"B", 1000110→"C", 0100001→"D", 0000110→"E", 0001110→"F", 1000010→"G", 0001001→"H", 1110001→"J", 0001010→"K", 1000111→"L", 0101011→"M", 0001100→"P", 0011000→"Q", 0001101→"R", 0000111→"T", 1000001→"U", 0101010→"W", 0010001→"Y".
  - Other: 1111111→" " (8'h20); any other pattern→"?" (8'h3F).

## Timing
- Reset values:
  - out_valid=0, out_data=8'h00, overrun=0.
  - FSM=IDLE; seen, pending-valid, counter and slots all zero.
  - first-frame flag set.
- Reset asserted mid-frame or mid-send aborts everything; the remaining bytes are never sent.
- Capture timing: {an, seg} applied constantly from edge t is captured at edge t+STABLE_CYCLES.
- Frame latency: out_valid rises on the edge after the frame-completing capture when the FSM is in IDLE.
- Handshake rules:
  - out_data is stable while out_valid && !out_ready.
  - out_valid never drops without an accept.
  - One byte per accepting cycle, so back-to-back transfers are allowed.
  - out_data=8'h00 whenever out_valid=0.
- Pending restart: with a pending frame, IDLE lasts exactly one cycle before SEND.
- Simultaneous events: a capture completing a frame on the same edge as the final TERM accept is treated as arriving in TERM. It goes to pending and is compared against the updated last_sent.
- A glitch (any change) during counting restarts the count; a captured digit is not re-captured until {an, seg} changes.

## Test plan
- Frame decode: scan "2","0","2","5" (digit 3 first), 20 cycles each, out_ready=1 → bytes 8'h32, 8'h30, 8'h32, 8'h35, 8'h0D; overrun stays 0.
- Repeat suppression and ambiguity: rescan the same frame → no output. Then scan patterns 0001001, 0101011, 1111111, 0110110 → "H", "M", " ", "?", CR.
- Glitch filter: toggle seg every 10 cycles with STABLE_CYCLES=16 → no capture and no output. Assert multiple anodes low for 40 cycles → no capture.
- Backpressure: out_ready=0 for 50 cycles after out_valid rises → out_data holds 8'h32. Release → remaining bytes follow one per cycle.
- Overrun: hold out_ready=0 and complete three distinct frames → one overrun pulse. After release, frame 1 is sent, then frame 3; frame 2 is never sent.
- Reset: assert rst after the second byte is accepted → next edge out_valid=0, out_data=8'h00. Rescan the original frame → it is sent in full (first-frame rule).

Source files
------------

// File: rtl/ssd_capture_decoder.sv
// ============================================================================
// Module      : ssd_capture_decoder
// Description : Recovers ASCII frames from a multiplexed active-low 7-segment
//               bus and streams changed frames (MSD first, then CR).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ssd_capture_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] an,
    input  logic [6:0]            seg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] C_IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][6:0] frame_t;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, TERM = 2'd2} state_t;

    function automatic logic [7:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = "0";
            7'b1111001: decode = "1";
            7'b0100100: decode = "2";
            7'b0110000: decode = "3";
            7'b0011001: decode = "4";
            7'b0010010: decode = "5";
            7'b0000010: decode = "6";
            7'b1111000: decode = "7";
            7'b0000000: decode = "8";
            7'b0010000: decode = "9";
            7'b0001000: decode = "A";
            7'b0000011: decode = "B";
            7'b1000110: decode = "C";
            7'b0100001: decode = "D";
            7'b0000110: decode = "E";
            7'b0001110: decode = "F";
            7'b1000010: decode = "G";
            7'b0001001: decode = "H";
            7'b1110001: decode = "J";
            7'b0001010: decode = "K";
            7'b1000111: decode = "L";
            7'b0101011: decode = "M";
            7'b0001100: decode = "P";
            7'b0011000: decode = "Q";
            7'b0001101: decode = "R";
            7'b0000111: decode = "T";
            7'b1000001: decode = "U";
            7'b0101010: decode = "W";
            7'b0010001: decode = "Y";
            7'b1111111: decode = 8'h20;
            default:    decode = 8'h3F;
        endcase
    endfunction

    logic [NUM_DIGITS+6:0] r_prev;
    logic [CW-1:0]         r_cnt;
    frame_t                r_slot, w_slot_nx;
    logic [NUM_DIGITS-1:0] r_seen, w_seen_nx;
    logic                  r_frame_v;
    frame_t                r_frame;

    state_t                r_state;
    frame_t                r_buf, r_last_sent, r_pend;
    logic [IW-1:0]         r_idx;
    logic                  r_first, r_pend_v;

    logic w_same, w_capture, w_cand, w_pend_ok;

    // Capture exactly on the edge the count reaches its saturation value.
    assign w_same    = ({an, seg} == r_prev);
    assign w_capture = w_same && (r_cnt == CW'(STABLE_CYCLES - 1)) && $onehot(~an);

    always_comb begin
        w_slot_nx = r_slot;
        w_seen_nx = r_seen;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_capture && !an[k]) begin
                w_slot_nx[k] = seg;
                w_seen_nx[k] = 1'b1;
            end
        end
    end

    assign w_cand    = r_frame_v && (r_first || (r_frame != r_last_sent));
    assign w_pend_ok = r_pend_v  && (r_first || (r_pend  != r_last_sent));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_cnt     <= '0;
            r_slot    <= '0;
            r_seen    <= '0;
            r_frame_v <= 1'b0;
            r_frame   <= '0;
        end else begin
            r_prev <= {an, seg};
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CW'(STABLE_CYCLES))
                r_cnt <= r_cnt + 1'b1;
            r_slot    <= w_slot_nx;
            r_frame_v <= &w_seen_nx;
            if (&w_seen_nx) begin
                r_seen  <= '0;
                r_frame <= w_slot_nx;
            end else begin
                r_seen  <= w_seen_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_last_sent <= '0;
            r_pend      <= '0;
            r_pend_v    <= 1'b0;
            r_idx       <= '0;
            r_first     <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A surviving pending frame goes first; a fresh one queues behind it.
                    if (w_pend_ok) begin
                        r_buf     <= r_pend;
                        r_idx     <= C_IDX_MAX;
                        out_valid <= 1'b1;
                        out_data  <= decode(r_pend[NUM_DIGITS-1]);
                        r_state   <= SEND;
                        r_pend_v  <= w_cand;
                        r_pend    <= r_frame;
                    end else if (w_cand) begin
                        r_buf     <= r_frame;
                        r_idx     <= C_IDX_MAX;
                        out_valid <= 1'b1;
                        out_data  <= decode(r_frame[NUM_DIGITS-1]);
                        r_state   <= SEND;
                        r_pend_v  <= 1'b0;
                    end else begin
                        r_pend_v  <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_cand) begin
                        r_pend   <= r_frame;
                        r_pend_v <= 1'b1;
                        overrun  <= r_pend_v;
                    end
                    if (out_ready) begin
                        if (r_idx != '0) begin
                            r_idx    <= r_idx - 1'b1;
                            out_data <= decode(r_buf[r_idx - 1'b1]);
                        end else begin
                            r_state  <= TERM;
                            out_data <= 8'h0D;
                        end
                    end
                end
                TERM: begin
                    if (w_cand) begin
                        r_pend   <= r_frame;
                        r_pend_v <= 1'b1;
                        overrun  <= r_pend_v;
                    end
                    if (out_ready) begin
                        r_last_sent <= r_buf;
                        r_first     <= 1'b0;
                        out_valid   <= 1'b0;
                        out_data    <= 8'h00;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ssd_capture_decoder.sv
// ============================================================================
// Module      : tb_ssd_capture_decoder
// Description : Directed self-checking bench for ssd_capture_decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ssd_capture_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 16;

    localparam logic [6:0] C_P0 = 7'b1000000, C_P1 = 7'b1111001, C_P2 = 7'b0100100;
    localparam logic [6:0] C_P3 = 7'b0110000, C_P4 = 7'b0011001, C_P5 = 7'b0010010;
    localparam logic [6:0] C_P6 = 7'b0000010, C_P7 = 7'b1111000, C_P8 = 7'b0000000;
    localparam logic [6:0] C_P9 = 7'b0010000, C_PA = 7'b0001000, C_PB = 7'b0000011;
    localparam logic [6:0] C_PC = 7'b1000110, C_PH = 7'b0001001, C_PM = 7'b0101011;
    localparam logic [6:0] C_PBL = 7'b1111111, C_PQ = 7'b0110110;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic                  overrun;

    int n_pass  = 0;
    int n_total = 0;
    int n_ovr   = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];

    ssd_capture_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) rx.push_back(out_data);
        if (!rst && overrun) n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_stream(input string tag);
        chk($sformatf("%s len", tag), rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx.size()) chk($sformatf("%s byte%0d", tag, i), rx[i], exp_q[i]);
    endtask

    task automatic scan_digit(input int k, input logic [6:0] p, input int n);
        an  = ~(NUM_DIGITS'(1) << k);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [6:0] d3, d2, d1, d0);
        scan_digit(3, d3, 20);
        scan_digit(2, d2, 20);
        scan_digit(1, d1, 20);
        scan_digit(0, d0, 20);
    endtask

    initial begin
        int bad;
        int t;
        rst = 1'b1; an = '1; seg = '1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 8'h00);
        chk("reset overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame "2025"
        rx.delete(); n_ovr = 0;
        scan_frame(C_P2, C_P0, C_P2, C_P5);
        repeat (15) @(negedge clk);
        exp_q = {8'h32, 8'h30, 8'h32, 8'h35, 8'h0D};
        check_stream("frame2025");
        chk("frame2025 overrun", n_ovr, 0);

        // Identical frame is suppressed
        rx.delete();
        scan_frame(C_P2, C_P0, C_P2, C_P5);
        repeat (15) @(negedge clk);
        chk("repeat suppressed", rx.size(), 0);

        // Letters, blank and unknown pattern
        rx.delete();
        scan_frame(C_PH, C_PM, C_PBL, C_PQ);
        repeat (15) @(negedge clk);
        exp_q = {8'h48, 8'h4D, 8'h20, 8'h3F, 8'h0D};
        check_stream("letters");

        // Glitch filter and multi-anode rejection while stalled
        rx.delete();
        out_ready = 1'b0;
        scan_digit(3, C_P2, 20);
        scan_digit(2, C_P0, 20);
        scan_digit(1, C_P2, 20);
        for (int i = 0; i < 10; i++) scan_digit(0, (i % 2) ? C_P6 : C_P5, 10);
        chk("glitch no frame", out_valid, 0);
        an = 4'b0011; seg = C_P5;
        repeat (40) @(negedge clk);
        chk("multi-anode no frame", out_valid, 0);

        // Backpressure: complete the frame, hold out_ready low
        scan_digit(0, C_P5, 20);
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        chk("bp valid rises", out_valid, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!out_valid || out_data !== 8'h32) bad++;
            @(negedge clk);
        end
        chk("bp hold violations", bad, 0);
        chk("bp hold data", out_data, 8'h32);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        exp_q = {8'h32, 8'h30, 8'h32, 8'h35, 8'h0D};
        check_stream("bp release");
        chk("bp drained", out_valid, 0);

        // Overrun: three distinct frames while stalled
        rx.delete(); n_ovr = 0;
        out_ready = 1'b0;
        scan_frame(C_P1, C_P2, C_P3, C_P4);
        scan_frame(C_P5, C_P6, C_P7, C_P8);
        scan_frame(C_P9, C_PA, C_PB, C_PC);
        repeat (3) @(negedge clk);
        chk("ovr pulses", n_ovr, 1);
        chk("ovr nothing sent", rx.size(), 0);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        exp_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h39, 8'h41, 8'h42, 8'h43, 8'h0D};
        check_stream("ovr stream");

        // Reset mid-send aborts the frame
        rx.delete();
        fork
            scan_frame(C_P2, C_P0, C_P2, C_P5);
            begin
                t = 0;
                while (rx.size() < 2 && t < 300) begin @(negedge clk); t++; end
                chk("rst two bytes seen", rx.size(), 2);
                rst = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                chk("rst out_valid", out_valid, 0);
                chk("rst out_data", out_data, 8'h00);
                rst = 1'b0; out_ready = 1'b1;
            end
        join
        rx.delete();
        repeat (30) @(negedge clk);
        chk("rst aborted", rx.size(), 0);
        scan_frame(C_P2, C_P0, C_P2, C_P5);
        repeat (15) @(negedge clk);
        exp_q = {8'h32, 8'h30, 8'h32, 8'h35, 8'h0D};
        check_stream("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
